mesi_snoop_cache: RTL and testbench

- Parametrised, direct-mapped L1 cache controller with per-line MESI state. Successor to the single-line MESI transition logic.
- Owns tag, data and state arrays. Serves one processor through a request/ready handshake.
- Issues BusRd, BusRdX and BusUpgr through a request/grant arbiter port, and writes back dirty victims.
- Snoops other caches' bus commands and updates line state. Several instances share one bus fabric and one memory.

---
 rtl/mesi_snoop_cache.sv | 240 ++++++++++++++++++++++++
 tb/tb_mesi_snoop_cache.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_snoop_cache.sv
// Direct-mapped L1 cache controller with per-line MESI state and a snooping port.
//
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   cpu_req/we/addr/wdata          processor request, held until cpu_ready
//   cpu_ready/cpu_rdata            one-cycle completion pulse and read data
//   bus_req/bus_gnt                bus arbitration handshake
//   bus_cmd/bus_addr               issued command (0 none, 1 BusRd, 2 BusRdX, 3 BusUpgr)
//   mem_valid/mem_rdata/bus_shared fill response from memory
//   wb_valid/wb_addr/wb_data/wb_ack dirty victim writeback handshake
//   snoop_valid/cmd/addr           another cache's bus command
//   snoop_hit/flush/data           registered snoop response
module mesi_snoop_cache #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned INDEX_W = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              bus_shared,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ack,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_hit,
  output logic              snoop_flush,
  output logic [DATA_W-1:0] snoop_data
);

  localparam int unsigned LINES = 2 ** INDEX_W;
  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  localparam logic [1:0] MesiI = 2'd0;
  localparam logic [1:0] MesiS = 2'd1;
  localparam logic [1:0] MesiM = 2'd2;
  localparam logic [1:0] MesiE = 2'd3;

  localparam logic [1:0] CmdNone = 2'd0;
  localparam logic [1:0] CmdRd   = 2'd1;
  localparam logic [1:0] CmdRdX  = 2'd2;
  localparam logic [1:0] CmdUpgr = 2'd3;

  typedef enum logic [2:0] {StIdle, StWb, StArb, StCmd, StFill} fsm_e;

  fsm_e fsm_q, fsm_d;
  logic [1:0]        pend_q, pend_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_we_q, req_we_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic              ready_q, ready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              snp_hit_q, snp_hit_d;
  logic              snp_flush_q, snp_flush_d;
  logic [DATA_W-1:0] snp_data_q, snp_data_d;

  logic [LINES-1:0][1:0]        state_q, state_snp, state_d;
  logic [LINES-1:0][TAG_W-1:0]  tag_q;
  logic [LINES-1:0][DATA_W-1:0] data_q;

  logic               tag_we, data_we;
  logic [INDEX_W-1:0] wr_idx;
  logic [DATA_W-1:0]  wr_data;

  logic [INDEX_W-1:0] cur_idx, req_idx, snp_idx;
  logic [TAG_W-1:0]   cur_tag, req_tag, snp_tag;
  logic               cur_hit, snp_match;

  assign cur_idx = cpu_addr[ADDR_W-1 -: INDEX_W];
  assign cur_tag = cpu_addr[TAG_W-1:0];
  assign req_idx = req_addr_q[ADDR_W-1 -: INDEX_W];
  assign req_tag = req_addr_q[TAG_W-1:0];
  assign snp_idx = snoop_addr[ADDR_W-1 -: INDEX_W];
  assign snp_tag = snoop_addr[TAG_W-1:0];

  assign cur_hit   = (state_q[cur_idx] != MesiI) && (tag_q[cur_idx] == cur_tag);
  assign snp_match = snoop_valid && (snoop_cmd != CmdNone) &&
                     (state_q[snp_idx] != MesiI) && (tag_q[snp_idx] == snp_tag);

  // Snoop update first; the FSM's own line writes are layered on top of it.
  always_comb begin
    state_snp   = state_q;
    snp_hit_d   = 1'b0;
    snp_flush_d = 1'b0;
    snp_data_d  = '0;
    if (snp_match) begin
      snp_hit_d = 1'b1;
      if (state_q[snp_idx] == MesiM && snoop_cmd != CmdUpgr) begin
        snp_flush_d = 1'b1;
        snp_data_d  = data_q[snp_idx];
      end
      state_snp[snp_idx] = (snoop_cmd == CmdRd) ? MesiS : MesiI;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    pend_d      = pend_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    state_d     = state_snp;
    ready_d     = 1'b0;
    rdata_d     = '0;
    tag_we      = 1'b0;
    data_we     = 1'b0;
    wr_idx      = req_idx;
    wr_data     = req_wdata_q;
    case (fsm_q)
      StIdle: begin
        // ready_q masks the still-held request of the transaction just completed;
        // a concurrent snoop stalls the lookup so it sees the updated state.
        if (cpu_req && !ready_q && !snoop_valid) begin
          req_addr_d  = cpu_addr;
          req_we_d    = cpu_we;
          req_wdata_d = cpu_wdata;
          if (cur_hit && !cpu_we) begin
            ready_d = 1'b1;
            rdata_d = data_q[cur_idx];
          end else if (cur_hit && state_q[cur_idx] != MesiS) begin
            ready_d          = 1'b1;
            data_we          = 1'b1;
            wr_idx           = cur_idx;
            wr_data          = cpu_wdata;
            state_d[cur_idx] = MesiM;
          end else if (cur_hit) begin
            pend_d = CmdUpgr;
            fsm_d  = StArb;
          end else if (state_q[cur_idx] == MesiM) begin
            fsm_d = StWb;
          end else begin
            pend_d = cpu_we ? CmdRdX : CmdRd;
            fsm_d  = StArb;
          end
        end
      end
      StWb: begin
        if (wb_ack) begin
          state_d[req_idx] = MesiI;
          pend_d           = req_we_q ? CmdRdX : CmdRd;
          fsm_d            = StArb;
        end
      end
      StArb: begin
        if (bus_gnt) begin
          // An upgrade loses its copy if a snoop invalidated the line while waiting.
          if (pend_q == CmdUpgr && state_snp[req_idx] != MesiS) pend_d = CmdRdX;
          fsm_d = StCmd;
        end
      end
      StCmd: begin
        if (pend_q == CmdUpgr) begin
          data_we          = 1'b1;
          state_d[req_idx] = MesiM;
          ready_d          = 1'b1;
          fsm_d            = StIdle;
        end else begin
          fsm_d = StFill;
        end
      end
      StFill: begin
        if (mem_valid) begin
          tag_we  = 1'b1;
          data_we = 1'b1;
          ready_d = 1'b1;
          fsm_d   = StIdle;
          if (req_we_q) begin
            state_d[req_idx] = MesiM;
          end else begin
            wr_data          = mem_rdata;
            rdata_d          = mem_rdata;
            state_d[req_idx] = bus_shared ? MesiS : MesiE;
          end
        end
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= StIdle;
      pend_q      <= CmdNone;
      req_addr_q  <= '0;
      req_we_q    <= 1'b0;
      req_wdata_q <= '0;
      state_q     <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      snp_hit_q   <= 1'b0;
      snp_flush_q <= 1'b0;
      snp_data_q  <= '0;
    end else begin
      fsm_q       <= fsm_d;
      pend_q      <= pend_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      state_q     <= state_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      snp_hit_q   <= snp_hit_d;
      snp_flush_q <= snp_flush_d;
      snp_data_q  <= snp_data_d;
    end
  end

  // Tag and data arrays carry no reset; line validity lives in state_q.
  always_ff @(posedge clock) begin
    if (tag_we)  tag_q[req_idx] <= req_tag;
    if (data_we) data_q[wr_idx] <= wr_data;
  end

  assign cpu_ready   = ready_q;
  assign cpu_rdata   = rdata_q;
  assign bus_req     = (fsm_q == StArb);
  assign bus_cmd     = (fsm_q == StCmd) ? pend_q : CmdNone;
  assign bus_addr    = (fsm_q == StCmd) ? req_addr_q : '0;
  assign wb_valid    = (fsm_q == StWb);
  assign wb_addr     = (fsm_q == StWb) ? {req_idx, tag_q[req_idx]} : '0;
  assign wb_data     = (fsm_q == StWb) ? data_q[req_idx] : '0;
  assign snoop_hit   = snp_hit_q;
  assign snoop_flush = snp_flush_q;
  assign snoop_data  = snp_data_q;

endmodule

// File: tb/tb_mesi_snoop_cache.sv
// Self-checking bench for mesi_snoop_cache: directed scenarios plus a randomized
// run against a transaction-level MESI model of the cache lines.
module tb_mesi_snoop_cache;

  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_M = 2'd2, ST_E = 2'd3;
  localparam logic [1:0] RD = 2'd1, RDX = 2'd2, UPGR = 2'd3;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_ready;
  logic [7:0] cpu_rdata;
  logic       bus_req, bus_gnt = 1'b0;
  logic [1:0] bus_cmd;
  logic [4:0] bus_addr;
  logic       mem_valid = 1'b0, bus_shared = 1'b0;
  logic [7:0] mem_rdata = '0;
  logic       wb_valid, wb_ack = 1'b0;
  logic [4:0] wb_addr;
  logic [7:0] wb_data;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_cmd = '0;
  logic [4:0] snoop_addr = '0;
  logic       snoop_hit, snoop_flush;
  logic [7:0] snoop_data;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-line MESI state, tag and data.
  logic [1:0] m_st[4];
  logic [2:0] m_tag[4];
  logic [7:0] m_data[4];

  mesi_snoop_cache #(.ADDR_W(5), .DATA_W(8), .INDEX_W(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata), .bus_shared(bus_shared),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ack(wb_ack),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
    .snoop_hit(snoop_hit), .snoop_flush(snoop_flush), .snoop_data(snoop_data)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0; bus_gnt = 1'b0; mem_valid = 1'b0; wb_ack = 1'b0; snoop_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Drives one CPU request and plays the bus fabric, memory and writeback sink.
  // Optionally injects one snoop on the first cycle bus_req is seen.
  task automatic cpu_op(
    input  logic we, input logic [4:0] addr, input logic [7:0] wd,
    input  logic shared, input logic [7:0] mdata,
    input  int gnt_dly, input int mem_dly, input int ack_dly,
    input  logic snp_en, input logic [1:0] snp_c, input logic [4:0] snp_a,
    output logic [7:0] rdata, output logic [1:0] cmd, output logic [4:0] cmd_addr,
    output logic wb_seen, output logic [4:0] wba, output logic [7:0] wbd,
    output logic snp_h, output logic snp_f, output logic [7:0] snp_d,
    output int cycles, output logic timeout);
    int gcnt, acnt, mcnt;
    logic mact, snp_pend, snp_done;
    gcnt = 0; acnt = 0; mcnt = 0; mact = 1'b0; snp_pend = 1'b0; snp_done = 1'b0;
    rdata = '0; cmd = '0; cmd_addr = '0; wb_seen = 1'b0; wba = '0; wbd = '0;
    snp_h = 1'b0; snp_f = 1'b0; snp_d = '0; cycles = 0; timeout = 1'b1;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      cycles++;
      if (snp_pend) begin
        snp_h = snoop_hit; snp_f = snoop_flush; snp_d = snoop_data; snp_pend = 1'b0;
      end
      snoop_valid = 1'b0;
      if (cpu_ready) begin
        rdata = cpu_rdata; timeout = 1'b0; break;
      end
      if (wb_valid) begin
        wb_seen = 1'b1; wba = wb_addr; wbd = wb_data;
        if (acnt == ack_dly) wb_ack = 1'b1; else acnt++;
      end else wb_ack = 1'b0;
      if (bus_req) begin
        if (snp_en && !snp_done) begin
          snoop_valid = 1'b1; snoop_cmd = snp_c; snoop_addr = snp_a;
          snp_done = 1'b1; snp_pend = 1'b1;
        end
        if (gcnt == gnt_dly) bus_gnt = 1'b1; else gcnt++;
      end else bus_gnt = 1'b0;
      if (mact) begin
        mcnt--;
        if (mcnt == 0) begin
          mem_valid = 1'b1; mem_rdata = mdata; bus_shared = shared; mact = 1'b0;
        end
      end else mem_valid = 1'b0;
      if (bus_cmd != 2'd0) begin
        cmd = bus_cmd; cmd_addr = bus_addr;
        if (bus_cmd != UPGR) begin mact = 1'b1; mcnt = mem_dly; end
      end
    end
    cpu_req = 1'b0; bus_gnt = 1'b0; mem_valid = 1'b0; wb_ack = 1'b0;
    bus_shared = 1'b0; snoop_valid = 1'b0;
  endtask

  task automatic snoop_op(input logic [1:0] c, input logic [4:0] a,
                          output logic h, output logic f, output logic [7:0] d);
    @(negedge clock);
    snoop_valid = 1'b1; snoop_cmd = c; snoop_addr = a;
    @(negedge clock);
    snoop_valid = 1'b0;
    h = snoop_hit; f = snoop_flush; d = snoop_data;
  endtask

  // Scratch outputs for the directed tests.
  logic [7:0] rd, wbd, sd;
  logic [1:0] cmd;
  logic [4:0] ca, wba;
  logic       wbs, sh, sf, to;
  int         cyc;

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clock);
    vectors++;
    if ({cpu_ready, cpu_rdata, bus_req, bus_cmd, bus_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_cpu_bus: got %h required 0",
               {cpu_ready, cpu_rdata, bus_req, bus_cmd, bus_addr});
    end
    vectors++;
    if ({wb_valid, wb_addr, wb_data, snoop_hit, snoop_flush, snoop_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_wb_snoop: got %h required 0",
               {wb_valid, wb_addr, wb_data, snoop_hit, snoop_flush, snoop_data});
    end
    do_reset();
  endtask

  task automatic test_read_miss_hit();
    cpu_op(1'b0, 5'h05, 8'h00, 1'b0, 8'h3C, 1, 2, 0, 1'b0, 2'd0, 5'h0,
           rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
    vectors++;
    if ({to, cmd, ca, wbs, rd} !== {1'b0, RD, 5'h05, 1'b0, 8'h3C} || cyc != 6) begin
      miscompares++;
      $display("FAIL read_miss: got to=%b cmd=%0d addr=%h wb=%b rdata=%h cyc=%0d required 0 1 05 0 3c 6",
               to, cmd, ca, wbs, rd, cyc);
    end
    cpu_op(1'b0, 5'h05, 8'h00, 1'b0, 8'h00, 0, 1, 0, 1'b0, 2'd0, 5'h0,
           rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
    vectors++;
    if ({to, cmd, rd} !== {1'b0, 2'd0, 8'h3C} || cyc != 1) begin
      miscompares++;
      $display("FAIL read_hit: got to=%b cmd=%0d rdata=%h cyc=%0d required 0 0 3c 1",
               to, cmd, rd, cyc);
    end
  endtask

  task automatic test_write_hit_snoop();
    cpu_op(1'b1, 5'h05, 8'hA1, 1'b0, 8'h00, 0, 1, 0, 1'b0, 2'd0, 5'h0,
           rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
    vectors++;
    if ({to, cmd, wbs} !== 4'b0 || cyc != 1) begin
      miscompares++;
      $display("FAIL write_hit_e: got to=%b cmd=%0d wb=%b cyc=%0d required 0 0 0 1",
               to, cmd, wbs, cyc);
    end
    snoop_op(RD, 5'h05, sh, sf, sd);
    vectors++;
    if ({sh, sf, sd} !== {1'b1, 1'b1, 8'hA1}) begin
      miscompares++;
      $display("FAIL snoop_rd_m: got hit=%b flush=%b data=%h required 1 1 a1", sh, sf, sd);
    end
    snoop_op(RD, 5'h05, sh, sf, sd);
    vectors++;
    if ({sh, sf} !== 2'b10) begin
      miscompares++;
      $display("FAIL snoop_rd_s: got hit=%b flush=%b required 1 0", sh, sf);
    end
  endtask

  task automatic test_upgrade();
    cpu_op(1'b1, 5'h05, 8'h77, 1'b0, 8'h00, 2, 1, 0, 1'b0, 2'd0, 5'h0,
           rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
    vectors++;
    if ({to, cmd, ca} !== {1'b0, UPGR, 5'h05} || cyc != 5) begin
      miscompares++;
      $display("FAIL upgrade: got to=%b cmd=%0d addr=%h cyc=%0d required 0 3 05 5",
               to, cmd, ca, cyc);
    end
    cpu_op(1'b0, 5'h05, 8'h00, 1'b0, 8'h00, 0, 1, 0, 1'b0, 2'd0, 5'h0,
           rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
    vectors++;
    if ({to, cmd, rd} !== {1'b0, 2'd0, 8'h77}) begin
      miscompares++;
      $display("FAIL upgrade_read: got to=%b cmd=%0d rdata=%h required 0 0 77", to, cmd, rd);
    end
    snoop_op(RD, 5'h05, sh, sf, sd);  // M -> S, leaves the line shared for the race test
    vectors++;
    if ({sh, sf, sd} !== {1'b1, 1'b1, 8'h77}) begin
      miscompares++;
      $display("FAIL upgrade_state_m: got hit=%b flush=%b data=%h required 1 1 77", sh, sf, sd);
    end
  endtask

  task automatic test_writeback();
    cpu_op(1'b1, 5'h09, 8'h55, 1'b0, 8'hF0, 0, 1, 0, 1'b0, 2'd0, 5'h0,
           rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
    vectors++;
    if ({to, cmd, ca, wbs} !== {1'b0, RDX, 5'h09, 1'b0} || cyc != 4) begin
      miscompares++;
      $display("FAIL write_miss: got to=%b cmd=%0d addr=%h wb=%b cyc=%0d required 0 2 09 0 4",
               to, cmd, ca, wbs, cyc);
    end
    cpu_op(1'b0, 5'h0D, 8'h00, 1'b1, 8'h66, 0, 1, 1, 1'b0, 2'd0, 5'h0,
           rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
    vectors++;
    if ({wbs, wba, wbd} !== {1'b1, 5'h09, 8'h55}) begin
      miscompares++;
      $display("FAIL writeback: got wb=%b addr=%h data=%h required 1 09 55", wbs, wba, wbd);
    end
    vectors++;
    if ({to, cmd, ca, rd} !== {1'b0, RD, 5'h0D, 8'h66} || cyc != 6) begin
      miscompares++;
      $display("FAIL wb_refill: got to=%b cmd=%0d addr=%h rdata=%h cyc=%0d required 0 1 0d 66 6",
               to, cmd, ca, rd, cyc);
    end
  endtask

  task automatic test_upgr_race();
    cpu_op(1'b1, 5'h05, 8'hC3, 1'b0, 8'h11, 2, 1, 0, 1'b1, RDX, 5'h05,
           rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
    vectors++;
    if ({sh, sf} !== 2'b10) begin
      miscompares++;
      $display("FAIL race_snoop: got hit=%b flush=%b required 1 0", sh, sf);
    end
    vectors++;
    if ({to, cmd, ca} !== {1'b0, RDX, 5'h05}) begin
      miscompares++;
      $display("FAIL race_cmd: got to=%b cmd=%0d addr=%h required 0 2 05", to, cmd, ca);
    end
    snoop_op(RD, 5'h05, sh, sf, sd);
    vectors++;
    if ({sh, sf, sd} !== {1'b1, 1'b1, 8'hC3}) begin
      miscompares++;
      $display("FAIL race_final_m: got hit=%b flush=%b data=%h required 1 1 c3", sh, sf, sd);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic found, rdy;
    found = 1'b0; rdy = 1'b0;
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'h12;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      bus_gnt = bus_req;
      if (bus_cmd != 2'd0) begin found = 1'b1; break; end
    end
    bus_gnt = 1'b0;
    vectors++;
    if (found !== 1'b1) begin
      miscompares++;
      $display("FAIL midfill_cmd_timeout: got %b required 1", found);
    end
    @(negedge clock);
    reset_n = 1'b0; cpu_req = 1'b0;
    #1;
    vectors++;
    if ({bus_req, wb_valid, cpu_ready, bus_cmd} !== 5'b0) begin
      miscompares++;
      $display("FAIL midfill_outputs: got %b required 00000", {bus_req, wb_valid, cpu_ready, bus_cmd});
    end
    mem_valid = 1'b1; mem_rdata = 8'hEE;
    @(negedge clock);
    mem_valid = 1'b0; reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock);
      if (cpu_ready) rdy = 1'b1;
    end
    vectors++;
    if (rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL midfill_no_ready: got %b required 0", rdy);
    end
    snoop_op(RD, 5'h05, sh, sf, sd);
    vectors++;
    if ({sh, sf} !== 2'b00) begin
      miscompares++;
      $display("FAIL midfill_line0_i: got hit=%b flush=%b required 0 0", sh, sf);
    end
    cpu_op(1'b0, 5'h0D, 8'h00, 1'b0, 8'h42, 0, 1, 0, 1'b0, 2'd0, 5'h0,
           rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
    vectors++;
    if ({to, cmd, wbs, rd} !== {1'b0, RD, 1'b0, 8'h42}) begin
      miscompares++;
      $display("FAIL midfill_remiss: got to=%b cmd=%0d wb=%b rdata=%h required 0 1 0 42",
               to, cmd, wbs, rd);
    end
  endtask

  task automatic test_random();
    logic       we, sh_in, hit, e_wb, e_f, e_h;
    logic [4:0] addr, e_wba, sa;
    logic [7:0] wd, md, e_rd, e_wbd, e_sd;
    logic [1:0] idx, e_cmd, sc;
    logic [2:0] tg;
    int         gd, mdl, ad, e_cyc;
    do_reset();
    for (int i = 0; i < 4; i++) m_st[i] = ST_I;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        we = 1'($urandom_range(0, 1));
        addr = {2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd1};
        wd = 8'($urandom); md = 8'($urandom); sh_in = 1'($urandom_range(0, 1));
        gd = $urandom_range(0, 3); mdl = $urandom_range(1, 3); ad = $urandom_range(0, 3);
        idx = addr[4:3]; tg = addr[2:0];
        hit = (m_st[idx] != ST_I) && (m_tag[idx] == tg);
        e_cmd = 2'd0; e_wb = 1'b0; e_wba = '0; e_wbd = '0; e_rd = '0; e_cyc = 1;
        if (hit && !we) begin
          e_rd = m_data[idx];
        end else if (hit && (m_st[idx] == ST_M || m_st[idx] == ST_E)) begin
          m_data[idx] = wd; m_st[idx] = ST_M;
        end else if (hit) begin
          e_cmd = UPGR; e_cyc = 3 + gd; m_data[idx] = wd; m_st[idx] = ST_M;
        end else begin
          if (m_st[idx] == ST_M) begin
            e_wb = 1'b1; e_wba = {idx, m_tag[idx]}; e_wbd = m_data[idx];
          end
          e_cmd = we ? RDX : RD;
          e_cyc = (e_wb ? ad + 1 : 0) + 3 + gd + mdl;
          m_tag[idx] = tg;
          if (we) begin
            m_data[idx] = wd; m_st[idx] = ST_M;
          end else begin
            m_data[idx] = md; m_st[idx] = sh_in ? ST_S : ST_E; e_rd = md;
          end
        end
        cpu_op(we, addr, wd, sh_in, md, gd, mdl, ad, 1'b0, 2'd0, 5'h0,
               rd, cmd, ca, wbs, wba, wbd, sh, sf, sd, cyc, to);
        vectors++;
        if ({to, cmd, ca} !== {1'b0, e_cmd, (e_cmd != 2'd0) ? addr : 5'h0} || cyc != e_cyc) begin
          miscompares++;
          $display("FAIL rand_bus[%0d]: got to=%b cmd=%0d addr=%h cyc=%0d required 0 %0d %h %0d",
                   n, to, cmd, ca, cyc, e_cmd, addr, e_cyc);
        end
        vectors++;
        if ({wbs, wba, wbd} !== {e_wb, e_wba, e_wbd}) begin
          miscompares++;
          $display("FAIL rand_wb[%0d]: got %b %h %h required %b %h %h",
                   n, wbs, wba, wbd, e_wb, e_wba, e_wbd);
        end
        if (!we) begin
          vectors++;
          if (rd !== e_rd) begin
            miscompares++;
            $display("FAIL rand_rdata[%0d]: got %h required %h", n, rd, e_rd);
          end
        end
      end else begin
        sc = 2'($urandom_range(1, 3));
        sa = {2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 0) ? 3'd5 : 3'd1};
        idx = sa[4:3];
        e_h = (m_st[idx] != ST_I) && (m_tag[idx] == sa[2:0]);
        e_f = e_h && (m_st[idx] == ST_M) && (sc != UPGR);
        e_sd = e_f ? m_data[idx] : 8'h00;
        if (e_h) m_st[idx] = (sc == RD) ? ST_S : ST_I;
        snoop_op(sc, sa, sh, sf, sd);
        vectors++;
        if ({sh, sf, sd} !== {e_h, e_f, e_sd}) begin
          miscompares++;
          $display("FAIL rand_snoop[%0d]: got %b %b %h required %b %b %h",
                   n, sh, sf, sd, e_h, e_f, e_sd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_miss_hit();
    test_write_hit_snoop();
    test_upgrade();
    test_writeback();
    test_upgr_race();
    test_reset_mid_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
